seg7_scan: RTL

- Downstream consumer of the clk_div divided clock. Drives the four-digit seven-segment display from a 16-bit hex value.
- Synchronises the divided clock into the system clock domain and edge-detects it to produce scan steps.
- Multiplexes one digit at a time, inserting a dead-time gap between digits to prevent ghosting.
- Supports per-digit blanking and per-digit blinking.

---
 rtl/seg7_scan_if.sv | 31 +++
 rtl/seg7_scan.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_if.sv
// Display-side bundle for seg7_scan.
//   data[15:0]     four hex nibbles, data[3:0] is digit 0
//   load           capture data into the display register
//   blank[3:0]     per-digit force-dark
//   blink_en[3:0]  per-digit dark during the blink-off phase
//   ds_seg[6:0]    segments {g,f,e,d,c,b,a}, active-high
//   ds_en[3:0]     one-hot digit enable, active-high
//   digit_idx[1:0] digit currently selected
//   state_dbg[1:0] scan FSM state (0 WAIT, 1 GAP, 2 SHOW)
// Handshake: there is no valid/ready pair; load is a single-cycle strobe
// sampled on every rising clk edge, and all other inputs are levels.
interface seg7_scan_if;
    logic [15:0] data;
    logic        load;
    logic [3:0]  blank;
    logic [3:0]  blink_en;
    logic [6:0]  ds_seg;
    logic [3:0]  ds_en;
    logic [1:0]  digit_idx;
    logic [1:0]  state_dbg;

    modport master (
        output data, load, blank, blink_en,
        input  ds_seg, ds_en, digit_idx, state_dbg
    );

    modport slave (
        input  data, load, blank, blink_en,
        output ds_seg, ds_en, digit_idx, state_dbg
    );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver.
// Each rising edge of the asynchronous scan_clk (after a 2-flop synchroniser
// and an edge detector) advances to the next digit. After every step all
// outputs are held off for DEAD_CYC cycles to avoid ghosting, then the
// selected digit is lit with the hex decode of its nibble unless it is
// blanked or in the off half of its blink period.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   scan_clk  divided scan clock, asynchronous to clk
//   bus       seg7_scan_if.slave (data/load/blank/blink_en in,
//             ds_seg/ds_en/digit_idx/state_dbg out)
module seg7_scan #(
    parameter int DEAD_CYC     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         scan_clk,
    seg7_scan_if.slave   bus
);

    localparam int GW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic [15:0]   disp;
    logic [1:0]    idx;
    logic [GW-1:0] gap_cnt;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [6:0]    seg_q;
    logic [3:0]    en_q;

    logic          step;
    logic          adv;
    state_t        nxt_state;
    logic [1:0]    nxt_idx;
    logic [GW-1:0] nxt_gap;
    logic [FW-1:0] nxt_frame;
    logic          nxt_phase;
    logic [15:0]   nxt_disp;
    logic          dark;
    logic          lit;
    logic [3:0]    nxt_nib;
    logic [6:0]    nxt_seg;
    logic [3:0]    nxt_en;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            4'hF: hex7 = 7'h71;
        endcase
    endfunction

    // One-cycle pulse on the synchronised rising edge of scan_clk.
    assign step = s2 & ~s3;

    // Next-state logic. Outputs are registered from the *next* index, phase
    // and display value so that a load, a blank/blink change or a step is
    // visible on the pins one cycle later.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_gap   = gap_cnt;
        nxt_frame = frame_cnt;
        nxt_phase = blink_phase;
        adv       = 1'b0;

        case (state)
            WAIT: begin
                // First step after reset keeps digit 0.
                if (step) begin
                    nxt_state = GAP;
                    nxt_gap   = '0;
                end
            end
            GAP: begin
                if (step) begin
                    adv     = 1'b1;
                    nxt_gap = '0;
                end else if (gap_cnt == GW'(DEAD_CYC - 1)) begin
                    nxt_state = SHOW;
                end else begin
                    nxt_gap = gap_cnt + 1'b1;
                end
            end
            SHOW: begin
                if (step) begin
                    nxt_state = GAP;
                    nxt_gap   = '0;
                    adv       = 1'b1;
                end
            end
            default: nxt_state = WAIT;
        endcase

        if (adv) begin
            nxt_idx = idx + 2'd1;
            // A 3 -> 0 wrap closes one frame of the blink period.
            if (idx == 2'd3) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    nxt_frame = '0;
                    nxt_phase = ~blink_phase;
                end else begin
                    nxt_frame = frame_cnt + 1'b1;
                end
            end
        end

        nxt_disp = bus.load ? bus.data : disp;
        dark     = bus.blank[nxt_idx] | (bus.blink_en[nxt_idx] & nxt_phase);
        lit      = (nxt_state == SHOW) && !dark;
        nxt_nib  = nxt_disp[{nxt_idx, 2'b00} +: 4];
        nxt_seg  = lit ? hex7(nxt_nib) : 7'h00;
        nxt_en   = lit ? (4'b0001 << nxt_idx) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            disp        <= 16'h0000;
            idx         <= 2'd0;
            gap_cnt     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            seg_q       <= 7'h00;
            en_q        <= 4'h0;
        end else begin
            s1          <= scan_clk;
            s2          <= s1;
            s3          <= s2;
            state       <= nxt_state;
            disp        <= nxt_disp;
            idx         <= nxt_idx;
            gap_cnt     <= nxt_gap;
            frame_cnt   <= nxt_frame;
            blink_phase <= nxt_phase;
            seg_q       <= nxt_seg;
            en_q        <= nxt_en;
        end
    end

    assign bus.ds_seg    = seg_q;
    assign bus.ds_en     = en_q;
    assign bus.digit_idx = idx;
    assign bus.state_dbg = state;

endmodule
